bram_stream_reader: RTL

//  Read-side sequencer for a bram_unit coefficient store (1-cycle registered read, no read enable).
//  On start, issues num_words consecutive read addresses from base_addr and streams the returned

---
 rtl/he_dft_pkg.sv | 27 ++
 rtl/bram_stream_reader_if.sv | 16 +
 rtl/stream_fifo2.sv | 53 +++++
 rtl/bram_stream_reader.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/he_dft_pkg.sv
// he_dft_pkg: shared definitions for the DFT coefficient path.
//   - Default DATA_WIDTH / ADDR_WIDTH for bram_unit and its readers.
//   - Reader FSM state enum.
//   - bitrev(): reverse the low n bits of a word, leaving upper bits untouched.
package he_dft_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 18;
    localparam int unsigned DEF_ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StFlush
    } state_e;

    // n = 0 returns v unchanged, which gives linear addressing.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int n);
        logic [31:0] r;
        r = v;
        for (int i = 0; i < 32; i++) begin
            if (i < n) r[i] = v[n - 1 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bram_stream_reader_if.sv
// bram_stream_reader_if: valid/ready coefficient stream.
//   m_valid  word valid (master -> slave)
//   m_ready  slave accepts when m_valid & m_ready
//   m_data   coefficient word
//   m_last   marks the final word of a burst
interface bram_stream_reader_if #(
    parameter int unsigned DATA_WIDTH = 18
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/stream_fifo2.sv
// stream_fifo2: 2-entry FIFO holding {last, data} words.
//   clk, rst   clock, async active-high reset (contents cleared to 0)
//   push       write push_data this cycle
//   pop        consume the head this cycle (caller only pops when not empty)
//   pop_data   head entry
//   count      occupancy 0..2
//   empty      count == 0
// Simultaneous push and pop are allowed even when full: the overwritten slot is
// the head that is consumed on the same edge.
module stream_fifo2 #(
    parameter int unsigned WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [1:0]       count,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign empty    = (count_q == 2'd0);

endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: streams num_words coefficients from a bram_unit (1-cycle
// registered read) starting at base_addr, on a valid/ready interface.
//   clk, rst         clock, async active-high reset
//   start            begin a burst (ignored while busy)
//   base_addr        first address, sampled with start
//   num_words        burst length 0..2^ADDR_WIDTH, sampled with start
//   rev_bits         (BIT_REVERSE_EN only) low offset bits to bit-reverse
//   busy             burst in progress
//   done             1-cycle pulse after the last word, or after a zero-length burst
//   bram_addr_read   read address to bram_unit
//   bram_data        read data from bram_unit
//   m                stream master (m_valid/m_ready/m_data/m_last)
// Optional feature macro: BIT_REVERSE_EN (adds rev_bits, bit-reversed addressing).
module bram_stream_reader
    import he_dft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_WIDTH-1:0]       base_addr,
    input  logic [ADDR_WIDTH:0]         num_words,
`ifdef BIT_REVERSE_EN
    input  logic [$clog2(ADDR_WIDTH+1)-1:0] rev_bits,
`endif
    output logic                        busy,
    output logic                        done,
    output logic [ADDR_WIDTH-1:0]       bram_addr_read,
    input  logic [DATA_WIDTH-1:0]       bram_data,
    bram_stream_reader_if.master        m
);

    state_e                state_q;
    logic                  busy_q;
    logic                  done_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   num_q;
    logic [ADDR_WIDTH:0]   offset_q;
    logic                  inflight_q;
    logic                  inflight_last_q;
`ifdef BIT_REVERSE_EN
    logic [$clog2(ADDR_WIDTH+1)-1:0] rev_q;
    logic [31:0]           rev_full;
`endif

    logic [1:0]            fifo_count;
    logic                  fifo_empty;
    logic [DATA_WIDTH:0]   fifo_out;
    logic                  pop;
    logic [2:0]            occupancy;
    logic                  issue;
    logic                  issue_last;
    logic [ADDR_WIDTH-1:0] offset_addr;

    assign pop = m.m_valid & m.m_ready;

    // Words held or on their way once this edge completes; keeps FIFO from overflowing.
    assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue      = (state_q == StRun) && (occupancy < 3'd2);
    assign issue_last = (offset_q == num_q - 1'b1);

`ifdef BIT_REVERSE_EN
    assign rev_full    = bitrev(32'(offset_q[ADDR_WIDTH-1:0]), int'(rev_q));
    assign offset_addr = rev_full[ADDR_WIDTH-1:0];
`else
    assign offset_addr = offset_q[ADDR_WIDTH-1:0];
`endif

    // Address is presented in the issue cycle and held otherwise.
    assign bram_addr_read = issue ? (base_q + offset_addr) : addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            base_q          <= '0;
            addr_q          <= '0;
            num_q           <= '0;
            offset_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
`ifdef BIT_REVERSE_EN
            rev_q           <= '0;
`endif
        end else begin
            done_q          <= 1'b0;
            addr_q          <= bram_addr_read;
            inflight_q      <= issue;
            inflight_last_q <= issue & issue_last;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        base_q   <= base_addr;
                        num_q    <= num_words;
                        offset_q <= '0;
                        busy_q   <= 1'b1;
`ifdef BIT_REVERSE_EN
                        rev_q    <= rev_bits;
`endif
                        if (num_words == '0) begin
                            state_q <= StFlush;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (issue) begin
                        offset_q <= offset_q + 1'b1;
                        if (issue_last) state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (pop && m.m_last) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StFlush: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    stream_fifo2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data ({inflight_last_q, bram_data}),
        .pop       (pop),
        .pop_data  (fifo_out),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign m.m_valid = ~fifo_empty;
    assign m.m_data  = fifo_out[DATA_WIDTH-1:0];
    assign m.m_last  = ~fifo_empty & fifo_out[DATA_WIDTH];

endmodule
